// File: rtl/snake_cell_draw_if.sv
// Pixel-write and tick-request bundle between the snake logic, snake_cell_draw and the VGA adapter.
// The master side is the snake logic (request) plus the adapter (pixel sink); the slave side is the renderer.
`timescale 1ns/1ps
interface snake_cell_draw_if;
    logic       start;
    logic [9:0] head_x;
    logic [8:0] head_y;
    logic [9:0] tail_x;
    logic [8:0] tail_y;
    logic       erase_en;
    logic [8:0] color;
    logic [9:0] VGA_X;
    logic [8:0] VGA_Y;
    logic [8:0] VGA_COLOR;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output start, head_x, head_y, tail_x, tail_y, erase_en, color,
        input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, overrun
    );

    modport slave (
        input  start, head_x, head_y, tail_x, tail_y, erase_en, color,
        output VGA_X, VGA_Y, VGA_COLOR, plot, busy, done, overrun
    );
endinterface

// File: rtl/snake_cell_draw.sv
// Render stage: clears the frame after reset, then per tick erases the old tail cell and paints the new head.
// Optional macro SNAKE_DRAW_BORDER_EN: white border ring drawn during clear and protected from later writes.
`timescale 1ns/1ps
module snake_cell_draw #(
    parameter int       SCREEN_W = 160,
    parameter int       SCREEN_H = 120,
    parameter int       CELL     = 4,
    parameter logic [8:0] BG_COLOR = 9'b000_000_000
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    snake_cell_draw_if.slave  bus
);

    localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam logic [CW-1:0] CELL_MAX = CW'(CELL - 1);
    localparam logic [8:0] BORDER_COLOR = 9'b111_111_111;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ERASE = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    cx_q, cx_d;
    logic [8:0]    cy_q, cy_d;
    logic [CW-1:0] dx_q, dx_d;
    logic [CW-1:0] dy_q, dy_d;
    logic          latch_s;
    logic          cell_last_s;

    logic [9:0]    head_x_q, tail_x_q;
    logic [8:0]    head_y_q, tail_y_q;
    logic [8:0]    color_q;

    logic [9:0]    base_x_s;
    logic [8:0]    base_y_s;
    logic [10:0]   px_full_s;
    logic [9:0]    py_full_s;
    logic          in_range_s;

    logic [9:0]    pix_x_s;
    logic [8:0]    pix_y_s;
    logic [8:0]    pix_c_s;
    logic          pix_plot_s;

    logic [9:0]    vga_x_q;
    logic [8:0]    vga_y_q;
    logic [8:0]    vga_color_q;
    logic          plot_q;
    logic          busy_q;
    logic          done_pend_q;
    logic          done_q;
    logic          overrun_q;

`ifdef SNAKE_DRAW_BORDER_EN
    function automatic logic on_border(input logic [10:0] x, input logic [9:0] y);
        on_border = (x == 11'd0) || (x == 11'(SCREEN_W - 1)) ||
                    (y == 10'd0) || (y == 10'(SCREEN_H - 1));
    endfunction
`endif

    assign cell_last_s = (dx_q == CELL_MAX) && (dy_q == CELL_MAX);

    // State register and sweep/cell counters.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_CLEAR;
            cx_q    <= 10'd0;
            cy_q    <= 9'd0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    // Next-state logic: raster sweep in CLEAR, cell walk in ERASE/DRAW.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        latch_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (cx_q == 10'(SCREEN_W - 1)) begin
                    cx_d = 10'd0;
                    if (cy_q == 9'(SCREEN_H - 1)) begin
                        cy_d    = 9'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cy_d = cy_q + 9'd1;
                    end
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    latch_s = 1'b1;
                    dx_d    = '0;
                    dy_d    = '0;
                    state_d = bus.erase_en ? ST_ERASE : ST_DRAW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE, ST_DRAW: begin
                if (dx_q == CELL_MAX) begin
                    dx_d = '0;
                    if (dy_q == CELL_MAX) begin
                        dy_d = '0;
                    end else begin
                        dy_d = dy_q + CW'(1);
                    end
                end else begin
                    dx_d = dx_q + CW'(1);
                end
                if (cell_last_s) begin
                    state_d = (state_q == ST_ERASE) ? ST_DRAW : ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Request latch; inputs are only meaningful on the accepting cycle.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            head_x_q <= 10'd0;
            head_y_q <= 9'd0;
            tail_x_q <= 10'd0;
            tail_y_q <= 9'd0;
            color_q  <= 9'd0;
        end else if (latch_s) begin
            head_x_q <= bus.head_x;
            head_y_q <= bus.head_y;
            tail_x_q <= bus.tail_x;
            tail_y_q <= bus.tail_y;
            color_q  <= bus.color;
        end else begin
            head_x_q <= head_x_q;
            head_y_q <= head_y_q;
            tail_x_q <= tail_x_q;
            tail_y_q <= tail_y_q;
            color_q  <= color_q;
        end
    end

    // Coordinates are widened by one bit so an off-screen cell clips instead of wrapping.
    assign base_x_s   = (state_q == ST_ERASE) ? tail_x_q : head_x_q;
    assign base_y_s   = (state_q == ST_ERASE) ? tail_y_q : head_y_q;
    assign px_full_s  = {1'b0, base_x_s} + 11'(dx_q);
    assign py_full_s  = {1'b0, base_y_s} + 10'(dy_q);
    assign in_range_s = (px_full_s < 11'(SCREEN_W)) && (py_full_s < 10'(SCREEN_H));

    // Pixel to present on the adapter port in the next cycle.
    always_comb begin
        pix_x_s    = vga_x_q;
        pix_y_s    = vga_y_q;
        pix_c_s    = vga_color_q;
        pix_plot_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                pix_x_s    = cx_q;
                pix_y_s    = cy_q;
                pix_plot_s = 1'b1;
`ifdef SNAKE_DRAW_BORDER_EN
                if (on_border({1'b0, cx_q}, {1'b0, cy_q})) begin
                    pix_c_s = BORDER_COLOR;
                end else begin
                    pix_c_s = BG_COLOR;
                end
`else
                pix_c_s    = BG_COLOR;
`endif
            end
            ST_ERASE, ST_DRAW: begin
                pix_x_s = px_full_s[9:0];
                pix_y_s = py_full_s[8:0];
                pix_c_s = (state_q == ST_ERASE) ? BG_COLOR : color_q;
`ifdef SNAKE_DRAW_BORDER_EN
                pix_plot_s = in_range_s && !on_border(px_full_s, py_full_s);
`else
                pix_plot_s = in_range_s;
`endif
            end
            ST_IDLE: begin
                pix_plot_s = 1'b0;
            end
            default: begin
                pix_plot_s = 1'b0;
            end
        endcase
    end

    // Registered outputs; done trails the last DRAW pixel by one cycle.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vga_x_q     <= 10'd0;
            vga_y_q     <= 9'd0;
            vga_color_q <= 9'd0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b1;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vga_x_q     <= pix_x_s;
            vga_y_q     <= pix_y_s;
            vga_color_q <= pix_c_s;
            plot_q      <= pix_plot_s;
            busy_q      <= (state_q != ST_IDLE);
            done_pend_q <= (state_q == ST_DRAW) && cell_last_s;
            done_q      <= done_pend_q;
            overrun_q   <= overrun_q | (bus.start && (state_q != ST_IDLE));
        end
    end

    assign bus.VGA_X     = vga_x_q;
    assign bus.VGA_Y     = vga_y_q;
    assign bus.VGA_COLOR = vga_color_q;
    assign bus.plot      = plot_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_snake_cell_draw.sv
// Directed bench for snake_cell_draw: frame clear, tick vectors from a table, overrun and mid-draw reset.
`timescale 1ns/1ps
module tb_snake_cell_draw;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    snake_cell_draw_if bus ();

    snake_cell_draw dut (
        .CLOCK_50 (clk),
        .resetn   (rstn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [9:0] hx;
        logic [8:0] hy;
        logic [9:0] tx;
        logic [8:0] ty;
        logic       er;
        logic [8:0] col;
        int         exp_plots;
        int         exp_lat;
        int         fx, fy, lx, ly;
    } vec_t;

    typedef struct {
        int         x;
        int         y;
        logic [8:0] c;
        logic       p;
    } pix_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic border(input int x, input int y);
`ifdef SNAKE_DRAW_BORDER_EN
        return (x == 0) || (x == 159) || (y == 0) || (y == 119);
`else
        return 1'b0;
`endif
    endfunction

    // Expected pixel number j of a tick request.
    function automatic pix_t model(input vec_t v, input int j);
        pix_t r;
        int   jj;
        int   bx;
        int   by;
        if (v.er && j < 16) begin
            bx = int'(v.tx); by = int'(v.ty); r.c = 9'd0; jj = j;
        end else begin
            bx = int'(v.hx); by = int'(v.hy); r.c = v.col; jj = v.er ? j - 16 : j;
        end
        r.x = bx + (jj % 4);
        r.y = by + (jj / 4);
        r.p = (r.x < 160) && (r.y < 120) && !border(r.x, r.y);
        return r;
    endfunction

    task automatic run_clear(input string tag);
        int busy_cnt = 0;
        int plots    = 0;
        int errs     = 0;
        int dones    = 0;
        int lx = -1, ly = -1;
        int first_c  = -1;
        logic [8:0] ec;
        for (int c = 1; c <= 19300; c++) begin
            tick();
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.done) dones++;
            if (bus.plot) begin
                ec = border(plots % 160, plots / 160) ? 9'h1FF : 9'h000;
                if (plots == 0) first_c = int'(bus.VGA_COLOR);
                if (int'(bus.VGA_X) != plots % 160 || int'(bus.VGA_Y) != plots / 160 ||
                    bus.VGA_COLOR != ec) errs++;
                lx = int'(bus.VGA_X);
                ly = int'(bus.VGA_Y);
                plots++;
            end else begin
                errs++;
            end
        end
        check({tag, " clear busy cycles"}, busy_cnt, 19200);
        check({tag, " clear plot count"}, plots, 19200);
        check({tag, " clear pixel errors"}, errs, 0);
        check({tag, " clear last x"}, lx, 159);
        check({tag, " clear last y"}, ly, 119);
        check({tag, " clear first colour"}, first_c, border(0, 0) ? 511 : 0);
        check({tag, " clear done pulses"}, dones, 0);
    endtask

    task automatic run_vec(input int i, input int inject);
        vec_t v;
        pix_t e;
        int   n;
        int   plots = 0;
        int   errs  = 0;
        int   lat   = -1;
        int   fx = -1, fy = -1, lx = -1, ly = -1;
        v = vecs[i];
        n = v.er ? 32 : 16;
        bus.start = 1'b1; bus.head_x = v.hx; bus.head_y = v.hy;
        bus.tail_x = v.tx; bus.tail_y = v.ty; bus.erase_en = v.er; bus.color = v.col;
        tick();
        bus.start = 1'b0; bus.head_x = 10'h3FF; bus.head_y = 9'h1FF;
        bus.tail_x = 10'h3FF; bus.tail_y = 9'h1FF; bus.erase_en = ~v.er; bus.color = 9'h155;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c <= n) begin
                e = model(v, c - 1);
                if (bus.plot != e.p) errs++;
                if (bus.plot && (int'(bus.VGA_X) != e.x || int'(bus.VGA_Y) != e.y ||
                                 bus.VGA_COLOR != e.c)) errs++;
                if (!bus.busy) errs++;
            end else if (bus.plot) begin
                errs++;
            end
            if (bus.plot) begin
                if (plots == 0) begin fx = int'(bus.VGA_X); fy = int'(bus.VGA_Y); end
                lx = int'(bus.VGA_X); ly = int'(bus.VGA_Y);
                plots++;
            end
            if (bus.done) begin
                lat = c;
                if (bus.busy) errs++;
                break;
            end
            if (c == inject) begin
                bus.start = 1'b1; bus.head_x = 10'd100; bus.head_y = 9'd50;
                bus.tail_x = 10'd60; bus.tail_y = 9'd30; bus.erase_en = 1'b1; bus.color = 9'h1FF;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check($sformatf("vec%0d done latency", i), lat, v.exp_lat);
        check($sformatf("vec%0d plot count", i), plots, v.exp_plots);
        check($sformatf("vec%0d pixel errors", i), errs, 0);
        check($sformatf("vec%0d first x", i), fx, v.fx);
        check($sformatf("vec%0d first y", i), fy, v.fy);
        check($sformatf("vec%0d last x", i), lx, v.lx);
        check($sformatf("vec%0d last y", i), ly, v.ly);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef SNAKE_DRAW_BORDER_EN
        vecs[0] = '{10'd8,   9'd4,   10'd0,   9'd4,  1'b1, 9'h038, 28, 33,   1,   4,  11,   7};
        vecs[1] = '{10'd156, 9'd116, 10'd0,   9'd0,  1'b0, 9'h1C0,  9, 17, 156, 116, 158, 118};
        vecs[2] = '{10'd158, 9'd118, 10'd0,   9'd0,  1'b0, 9'h0A5,  1, 17, 158, 118, 158, 118};
        vecs[3] = '{10'd40,  9'd40,  10'd40,  9'd40, 1'b1, 9'h007, 32, 33,  40,  40,  43,  43};
        vecs[4] = '{10'd20,  9'd20,  10'd157, 9'd10, 1'b1, 9'h1F8, 24, 33, 157,  10,  23,  23};
`else
        vecs[0] = '{10'd8,   9'd4,   10'd0,   9'd4,  1'b1, 9'h038, 32, 33,   0,   4,  11,   7};
        vecs[1] = '{10'd156, 9'd116, 10'd0,   9'd0,  1'b0, 9'h1C0, 16, 17, 156, 116, 159, 119};
        vecs[2] = '{10'd158, 9'd118, 10'd0,   9'd0,  1'b0, 9'h0A5,  4, 17, 158, 118, 159, 119};
        vecs[3] = '{10'd40,  9'd40,  10'd40,  9'd40, 1'b1, 9'h007, 32, 33,  40,  40,  43,  43};
        vecs[4] = '{10'd20,  9'd20,  10'd157, 9'd10, 1'b1, 9'h1F8, 28, 33, 157,  10,  23,  23};
`endif
        rstn = 1'b0;
        bus.start = 1'b0; bus.head_x = 10'd0; bus.head_y = 9'd0;
        bus.tail_x = 10'd0; bus.tail_y = 9'd0; bus.erase_en = 1'b0; bus.color = 9'd0;
        repeat (2) tick();
        check("reset plot", int'(bus.plot), 0);
        check("reset vga_x", int'(bus.VGA_X), 0);
        check("reset vga_y", int'(bus.VGA_Y), 0);
        check("reset colour", int'(bus.VGA_COLOR), 0);
        check("reset busy", int'(bus.busy), 1);
        check("reset done", int'(bus.done), 0);
        check("reset overrun", int'(bus.overrun), 0);
        rstn = 1'b1;
        run_clear("first");

        // Back-to-back: each new start is issued in the cycle done is high.
        for (int i = 0; i < 5; i++) run_vec(i, 0);
        check("overrun before injection", int'(bus.overrun), 0);

        run_vec(0, 5);
        check("overrun after injection", int'(bus.overrun), 1);
        run_vec(1, 0);
        check("overrun still sticky", int'(bus.overrun), 1);
        tick();
        check("done pulse width", int'(bus.done), 0);
        check("idle busy", int'(bus.busy), 0);

        // Abort in the middle of DRAW.
        bus.start = 1'b1; bus.head_x = 10'd80; bus.head_y = 9'd60; bus.erase_en = 1'b0;
        bus.color = 9'h0FF;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("mid-draw plotting", int'(bus.plot), 1);
        rstn = 1'b0;
        #1;
        check("abort plot", int'(bus.plot), 0);
        check("abort busy", int'(bus.busy), 1);
        check("abort overrun", int'(bus.overrun), 0);
        check("abort vga_x", int'(bus.VGA_X), 0);
        tick();
        rstn = 1'b1;
        run_clear("second");
        check("overrun after reset", int'(bus.overrun), 0);
        run_vec(3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
